// File: rtl/tick_debouncer_if.sv
// Button debouncer signal bundle: tick enable and raw levels go in,
// clean levels and press/release pulses come out.
interface tick_debouncer_if #(
  parameter int NUM_BTN = 5
);
  logic               tick_in;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (
    output tick_in,
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  tick_in,
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/tick_debouncer.sv
// Per-button debouncer clocked by clk_in, using tick_in as the time base.
// Each raw input is synchronized, then must hold a new level for
// STABLE_TICKS tick strobes before it is accepted.
//
// state        | meaning
// -------------+----------------------------------------------------------
// RELEASED     | stable released, btn_level = 0
// PRESS_WAIT   | sync high, counting ticks toward accepting a press
// PRESSED      | stable pressed, btn_level = 1
// RELEASE_WAIT | sync low, counting ticks toward accepting a release
module tick_debouncer #(
  parameter int NUM_BTN      = 5,
  parameter int STABLE_TICKS = 4,
  parameter int CNT_W        = 3
) (
  input  logic            clk_in,
  input  logic            rst_n,
  tick_debouncer_if.slave bus
);

  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  // Count of the last tick before acceptance; the counter stops here and
  // the state transition happens instead, so it never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [NUM_BTN-1:0] sync_meta;
  logic [NUM_BTN-1:0] sync_q;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] press_q;
  logic [NUM_BTN-1:0] release_q;

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= bus.btn_raw;
      sync_q    <= sync_meta;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             lvl_q;
    logic             prs_q;
    logic             rls_q;

    // Channel FSM with its stability counter; pulses default low each cycle.
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        prs_q   <= 1'b0;
        rls_q   <= 1'b0;
      end else begin
        prs_q <= 1'b0;
        rls_q <= 1'b0;
        case (state_q)
          RELEASED: begin
            // A tick on the entry cycle is deliberately not counted.
            if (sync_q[i]) begin
              state_q <= PRESS_WAIT;
              cnt_q   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!sync_q[i]) begin
              state_q <= RELEASED;
              cnt_q   <= '0;
            end else if (bus.tick_in) begin
              if (cnt_q == CNT_LAST) begin
                state_q <= PRESSED;
                cnt_q   <= '0;
                lvl_q   <= 1'b1;
                prs_q   <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          PRESSED: begin
            if (!sync_q[i]) begin
              state_q <= RELEASE_WAIT;
              cnt_q   <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (sync_q[i]) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end else if (bus.tick_in) begin
              if (cnt_q == CNT_LAST) begin
                state_q <= RELEASED;
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
                rls_q   <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          default: begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
          end
        endcase
      end
    end

    assign level_q[i]   = lvl_q;
    assign press_q[i]   = prs_q;
    assign release_q[i] = rls_q;
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;

endmodule
